// File: rtl/vga_timing_pkg.sv
// Default 640x480 timing constants and lock-state encoding shared by the VGA timing decoder.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lock_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer with asynchronous active-low reset; resets to 1 (idle level of active-low syncs).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // two flops in series to settle metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers pixel position, data enable and lock status from incoming active-low hsync/vsync.
// Define VGA_DEC_SYNC_EN to resynchronize hsync/vsync through sync_2ff (adds 2 clocks of latency).
module vga_timing_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       de,
   output logic       line_start,
   output logic       frame_start,
   output logic       locked,
   output logic       err
);

   localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_START  = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_END    = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] V_START  = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_END    = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [9:0] CNT_MAX  = 10'd1023;
   localparam logic [9:0] CNT_DROP = 10'd1022;

   logic        hs_in_s, vs_in_s;
   logic        hs_r, hs_d_r, vs_r, vs_d_r;
   logic        hs_fall_s, vs_fall_s, reload_s;
   logic [9:0]  hcnt_r, vcnt_r, hcnt_nxt_s, vcnt_nxt_s;
   logic        vs_pend_r, vs_pend_nxt_s;
   logic        line_err_s, frame_err_s, err_s;
   lock_state_e state_r, state_nxt_s;
   logic [1:0]  bound_cnt_r, bound_cnt_nxt_s;
   logic        h_act_s, v_act_s, de_nxt_s;
   logic [9:0]  x_nxt_s, y_nxt_s;

`ifdef VGA_DEC_SYNC_EN
   sync_2ff u_hs_sync (.clk(clk), .rst_n(rst_n), .d(hsync), .q(hs_in_s));
   sync_2ff u_vs_sync (.clk(clk), .rst_n(rst_n), .d(vsync), .q(vs_in_s));
`else
   assign hs_in_s = hsync;
   assign vs_in_s = vsync;
`endif

   assign hs_fall_s = hs_d_r & ~hs_r;
   assign vs_fall_s = vs_d_r & ~vs_r;
   assign reload_s  = hs_fall_s & (vs_pend_r | vs_fall_s);

   // counters, pending-vsync tracking and length checks
   always_comb begin
      hcnt_nxt_s    = hcnt_r;
      vcnt_nxt_s    = vcnt_r;
      vs_pend_nxt_s = vs_pend_r;
      if (hs_fall_s) begin
         hcnt_nxt_s = 10'd0;
      end else if (hcnt_r != CNT_MAX) begin
         hcnt_nxt_s = hcnt_r + 10'd1;
      end else begin
         hcnt_nxt_s = hcnt_r;
      end
      if (reload_s) begin
         vcnt_nxt_s = 10'd0;
      end else if (hs_fall_s && (vcnt_r != CNT_MAX)) begin
         vcnt_nxt_s = vcnt_r + 10'd1;
      end else begin
         vcnt_nxt_s = vcnt_r;
      end
      if (reload_s) begin
         vs_pend_nxt_s = 1'b0;
      end else if (vs_fall_s) begin
         vs_pend_nxt_s = 1'b1;
      end else begin
         vs_pend_nxt_s = vs_pend_r;
      end
      // a missing hsync is flagged once, as the counter reaches saturation
      line_err_s  = (hs_fall_s && (hcnt_r != H_LAST)) || (!hs_fall_s && (hcnt_r == CNT_DROP));
      frame_err_s = reload_s && (vcnt_r != V_LAST);
      err_s       = line_err_s | frame_err_s;
   end

   // lock FSM; bound_cnt counts clean frame boundaries seen in VERIFY (start + two ends)
   always_comb begin
      state_nxt_s     = state_r;
      bound_cnt_nxt_s = bound_cnt_r;
      case (state_r)
         SEARCH: begin
            if (vs_fall_s) begin
               state_nxt_s     = VERIFY;
               bound_cnt_nxt_s = reload_s ? 2'd1 : 2'd0;
            end else begin
               state_nxt_s     = SEARCH;
               bound_cnt_nxt_s = 2'd0;
            end
         end
         VERIFY: begin
            if (err_s) begin
               state_nxt_s     = SEARCH;
               bound_cnt_nxt_s = 2'd0;
            end else if (reload_s && (bound_cnt_r == 2'd2)) begin
               state_nxt_s     = LOCKED;
               bound_cnt_nxt_s = 2'd0;
            end else if (reload_s) begin
               state_nxt_s     = VERIFY;
               bound_cnt_nxt_s = bound_cnt_r + 2'd1;
            end else begin
               state_nxt_s     = VERIFY;
               bound_cnt_nxt_s = bound_cnt_r;
            end
         end
         LOCKED: begin
            if (err_s) begin
               state_nxt_s = SEARCH;
            end else begin
               state_nxt_s = LOCKED;
            end
            bound_cnt_nxt_s = 2'd0;
         end
         default: begin
            state_nxt_s     = SEARCH;
            bound_cnt_nxt_s = 2'd0;
         end
      endcase
   end

   // outputs are computed from next-state counters so they register in step with them
   always_comb begin
      h_act_s  = (hcnt_nxt_s >= H_START) && (hcnt_nxt_s < H_END);
      v_act_s  = (vcnt_nxt_s >= V_START) && (vcnt_nxt_s < V_END);
      de_nxt_s = (state_nxt_s == LOCKED) && h_act_s && v_act_s;
      if (de_nxt_s) begin
         x_nxt_s = hcnt_nxt_s - H_START;
         y_nxt_s = vcnt_nxt_s - V_START;
      end else begin
         x_nxt_s = 10'd0;
         y_nxt_s = 10'd0;
      end
   end

   // input registers with one cycle of history for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_r   <= 1'b1;
         hs_d_r <= 1'b1;
         vs_r   <= 1'b1;
         vs_d_r <= 1'b1;
      end else begin
         hs_r   <= hs_in_s;
         hs_d_r <= hs_r;
         vs_r   <= vs_in_s;
         vs_d_r <= vs_r;
      end
   end

   // counter and FSM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_r      <= 10'd0;
         vcnt_r      <= 10'd0;
         vs_pend_r   <= 1'b0;
         state_r     <= SEARCH;
         bound_cnt_r <= 2'd0;
      end else begin
         hcnt_r      <= hcnt_nxt_s;
         vcnt_r      <= vcnt_nxt_s;
         vs_pend_r   <= vs_pend_nxt_s;
         state_r     <= state_nxt_s;
         bound_cnt_r <= bound_cnt_nxt_s;
      end
   end

   // registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x           <= 10'd0;
         y           <= 10'd0;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         err         <= 1'b0;
      end else begin
         x           <= x_nxt_s;
         y           <= y_nxt_s;
         de          <= de_nxt_s;
         line_start  <= hs_fall_s;
         frame_start <= vs_fall_s;
         locked      <= (state_nxt_s == LOCKED);
         err         <= err_s;
      end
   end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a reduced raster (28 clocks x 11 lines) so frames stay short.
module tb_vga_timing_decoder;

   localparam int HA = 16;
   localparam int HF = 5;
   localparam int HS = 4;
   localparam int HB = 3;
   localparam int VA = 6;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
`ifdef VGA_DEC_SYNC_EN
   localparam int D = 3;
`else
   localparam int D = 1;
`endif

   logic       clk;
   logic       rst_n;
   logic       hsync;
   logic       vsync;
   logic [9:0] x;
   logic [9:0] y;
   logic       de;
   logic       line_start;
   logic       frame_start;
   logic       locked;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string name;
      int    nrows;
      int    short_row;
      bit    de_lock;
      int    n_err;
      bit    lock_end;
   } frame_vec_t;

   frame_vec_t vecs[13];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_timing_decoder #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
      .x(x), .y(y), .de(de), .line_start(line_start), .frame_start(frame_start),
      .locked(locked), .err(err)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives rows [first_row, last_row) of the raster; vsync is low on rows 0..VS-1, coincident with hsync.
   task automatic run_rows(input string name, input int first_row, input int last_row, input int short_row,
                           input bit de_lock, input int n_err, input bit lock_end);
      int pix_bad, ls_bad, fs_bad, err_cnt, lae_bad;
      int len, h;
      bit exp_de, prev_err;
      pix_bad = 0; ls_bad = 0; fs_bad = 0; err_cnt = 0; lae_bad = 0; prev_err = 1'b0;
      for (int r = first_row; r < last_row; r++) begin
         len = (r == short_row) ? HT - 1 : HT;
         for (int p = 0; p < len; p++) begin
            hsync = (p < HS) ? 1'b0 : 1'b1;
            vsync = (r < VS) ? 1'b0 : 1'b1;
            tick();
            h = p - D;
            exp_de = de_lock && (h >= HS + HB) && (h < HS + HB + HA) && (r >= VS + VB) && (r < VS + VB + VA);
            if (de !== exp_de) pix_bad++;
            else if (exp_de && ((x !== 10'(h - HS - HB)) || (y !== 10'(r - VS - VB)))) pix_bad++;
            else if (!exp_de && ((x !== 10'd0) || (y !== 10'd0))) pix_bad++;
            if (line_start !== (p == D)) ls_bad++;
            if (frame_start !== ((r == 0) && (p == D))) fs_bad++;
            if (prev_err && (locked !== 1'b0)) lae_bad++;
            if (err === 1'b1) err_cnt++;
            prev_err = (err === 1'b1);
         end
      end
      check({name, "_pixels"}, pix_bad, 0);
      check({name, "_line_start"}, ls_bad, 0);
      check({name, "_frame_start"}, fs_bad, 0);
      check({name, "_err_count"}, err_cnt, n_err);
      check({name, "_lock_after_err"}, lae_bad, 0);
      check({name, "_locked_end"}, int'(locked), int'(lock_end));
   endtask

   initial begin
      int drop_errs, drop_at, lock_mid, drop_bad;

      //                name            rows short de_lock errs lock_end
      vecs[0]  = '{"f0_first_vs",    VT,  -1,  1'b0,   1,   1'b0};
      vecs[1]  = '{"f1_verify",      VT,  -1,  1'b0,   0,   1'b0};
      vecs[2]  = '{"f2_lock",        VT,  -1,  1'b1,   0,   1'b1};
      vecs[3]  = '{"f3_locked",      VT,  -1,  1'b1,   0,   1'b1};
      vecs[4]  = '{"f4_short_line",  VT,   1,  1'b0,   1,   1'b0};
      vecs[5]  = '{"f5_reverify",    VT,  -1,  1'b0,   0,   1'b0};
      vecs[6]  = '{"f6_reverify",    VT,  -1,  1'b0,   0,   1'b0};
      vecs[7]  = '{"f7_relock",      VT,  -1,  1'b1,   0,   1'b1};
      vecs[8]  = '{"f8_short_frame", VT-1, -1, 1'b1,   0,   1'b1};
      vecs[9]  = '{"f9_frame_err",   VT,  -1,  1'b0,   1,   1'b0};
      vecs[10] = '{"f10_search",     VT,  -1,  1'b0,   0,   1'b0};
      vecs[11] = '{"f11_verify",     VT,  -1,  1'b0,   0,   1'b0};
      vecs[12] = '{"f12_lock",       VT,  -1,  1'b1,   0,   1'b1};

      rst_n = 1'b0;
      hsync = 1'b1;
      vsync = 1'b1;
      repeat (2) tick();
      check("reset_de", int'(de), 0);
      check("reset_locked", int'(locked), 0);
      check("reset_xy", int'({x, y}), 0);
      check("reset_pulses", int'({line_start, frame_start, err}), 0);
      rst_n = 1'b1;
      repeat (5) tick();

      for (int i = 0; i < 13; i++) begin
         run_rows(vecs[i].name, 0, vecs[i].nrows, vecs[i].short_row,
                  vecs[i].de_lock, vecs[i].n_err, vecs[i].lock_end);
      end

      // hsync stuck high after a line start: one error when the counter saturates
      drop_errs = 0; drop_at = -1; lock_mid = 0; drop_bad = 0;
      for (int p = 0; p < 1100; p++) begin
         hsync = (p < HS) ? 1'b0 : 1'b1;
         vsync = 1'b1;
         tick();
         if (p == 1000) lock_mid = int'(locked);
         if (err === 1'b1) begin
            drop_errs++;
            drop_at = p;
         end
         if ((p > 1023 + D) && ((locked !== 1'b0) || (de !== 1'b0))) drop_bad++;
      end
      check("drop_err_count", drop_errs, 1);
      check("drop_err_pos", drop_at, 1023 + D);
      check("drop_locked_before", lock_mid, 1);
      check("drop_unlocked_after", drop_bad, 0);

      run_rows("rec0", 0, VT, -1, 1'b0, 1, 1'b0);
      run_rows("rec1", 0, VT, -1, 1'b0, 0, 1'b0);
      run_rows("rec2", 0, VT, -1, 1'b1, 0, 1'b1);

      // asynchronous reset in the middle of an active line
      run_rows("pre_rst", 0, 5, -1, 1'b1, 0, 1'b1);
      for (int p = 0; p < 12; p++) begin
         hsync = (p < HS) ? 1'b0 : 1'b1;
         vsync = 1'b1;
         tick();
      end
      check("pre_rst_de", int'(de), 1);
      check("pre_rst_x", int'(x), 11 - D - HS - HB);
      #2 rst_n = 1'b0;
      #1;
      check("rst_de", int'(de), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_pulses", int'({line_start, frame_start, err}), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      run_rows("post_rst", 6, VT, -1, 1'b0, 1, 1'b0);
      run_rows("pr0", 0, VT, -1, 1'b0, 1, 1'b0);
      run_rows("pr1", 0, VT, -1, 1'b0, 0, 1'b0);
      run_rows("pr2", 0, VT, -1, 1'b1, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
